// File: rtl/snake_head_stepper_pkg.sv
// Shared snake-game direction encoding and helpers, reused by button capture,
// head stepping and body logic.
package snake_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_RIGHT = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_LEFT  = 3'd4;
  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Invalid codes map to 0, which never matches a legal request.
  function automatic dir_t opposite_dir(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic dir_legal(input dir_t d);
    return (d >= DIR_UP) && (d <= DIR_LEFT);
  endfunction

endpackage

// File: rtl/snake_head_stepper_if.sv
// Direction request in, head position and step strobes out.
interface snake_head_stepper_if #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5
) ();
  logic [2:0]        dir_in;
  logic              enable;
  logic [X_BITS-1:0] head_x;
  logic [Y_BITS-1:0] head_y;
  logic [2:0]        cur_dir;
  logic              step_valid;
  logic              wrapped;

  modport master (
    output dir_in, enable,
    input  head_x, head_y, cur_dir, step_valid, wrapped
  );

  modport slave (
    input  dir_in, enable,
    output head_x, head_y, cur_dir, step_valid, wrapped
  );
endinterface

// File: rtl/snake_head_stepper_step_timer.sv
// Game-tick divider: counts enabled cycles and strobes on the last one.
module step_timer #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Strobe is combinational so the head updates on the same edge that clears cnt.
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/snake_head_stepper.sv
// Advances the snake head one grid cell per game tick, filtering illegal and
// reversing direction requests and wrapping at the grid edges.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 5,
  parameter int TICK_DIV = 25_000_000,
  parameter int START_X  = 4,
  parameter int START_Y  = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  snake_head_stepper_if.slave  bus
);
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);

  logic              tick;
  dir_t              cur_dir, pending_dir, ref_dir;
  logic              dir_ok;
  logic [X_BITS-1:0] head_x, nx;
  logic [Y_BITS-1:0] head_y, ny;
  logic              nwrap;
  logic              step_valid, wrapped;

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk    (clk),
    .resetn (resetn),
    .enable (bus.enable),
    .tick   (tick)
  );

  // On a step edge the reversal check is against the direction being committed.
  always_comb begin
    ref_dir = tick ? pending_dir : cur_dir;
    dir_ok  = dir_legal(bus.dir_in) && (bus.dir_in != opposite_dir(ref_dir));
  end

  always_comb begin
    nx    = head_x;
    ny    = head_y;
    nwrap = 1'b0;
    case (pending_dir)
      DIR_UP: begin
        if (head_y == '0) begin ny = Y_MAX; nwrap = 1'b1; end
        else ny = head_y - Y_BITS'(1);
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin ny = '0; nwrap = 1'b1; end
        else ny = head_y + Y_BITS'(1);
      end
      DIR_RIGHT: begin
        if (head_x == X_MAX) begin nx = '0; nwrap = 1'b1; end
        else nx = head_x + X_BITS'(1);
      end
      DIR_LEFT: begin
        if (head_x == '0) begin nx = X_MAX; nwrap = 1'b1; end
        else nx = head_x - X_BITS'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_x      <= X_BITS'(START_X);
      head_y      <= Y_BITS'(START_Y);
      cur_dir     <= DIR_RESET;
      pending_dir <= DIR_RESET;
      step_valid  <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      if (dir_ok) pending_dir <= bus.dir_in;
      step_valid <= tick;
      wrapped    <= tick && nwrap;
      if (tick) begin
        cur_dir <= pending_dir;
        head_x  <= nx;
        head_y  <= ny;
      end
    end
  end

  assign bus.head_x     = head_x;
  assign bus.head_y     = head_y;
  assign bus.cur_dir    = cur_dir;
  assign bus.step_valid = step_valid;
  assign bus.wrapped    = wrapped;
endmodule
